// File: rtl/piece_lock.sv
// Board-RAM writer for a landed tetromino: commits the piece's cells, then scans
// bottom-up, removing every full row and dropping the rows above it by one.
module piece_lock #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [4:0]        X_anchor,
  input  logic [5:0]        Y_anchor,
  input  logic [2:0]        block,
  input  logic [5:0]        colour_in,
  input  logic [5:0]        ram_Q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [5:0]        ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              complete,
  output logic [2:0]        lines_cleared
);

  localparam int ROW_W = $clog2(BOARD_H);
  localparam int COL_W = $clog2(BOARD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_SCAN,
    S_SHIFT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       x_q, x_d;
  logic [5:0]       y_q, y_d;
  logic [2:0]       block_q, block_d;
  logic [5:0]       colour_q, colour_d;
  logic [3:0]       idx_q, idx_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] dst_q, dst_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             ph_q, ph_d;
  logic             zero_q, zero_d;
  logic             full_q, full_d;
  logic [2:0]       lines_q, lines_d;

  logic [15:0] mask;
  logic [6:0]  cell_x;
  logic [6:0]  cell_y;
  logic        cell_on;

  function automatic logic [15:0] shape_mask(input logic [2:0] id);
    case (id)
      3'd0:    return 16'h0F00;
      3'd1:    return 16'h6600;
      3'd2:    return 16'h4E00;
      3'd3:    return 16'h6C00;
      3'd4:    return 16'hC600;
      3'd5:    return 16'h8E00;
      3'd6:    return 16'h2E00;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] yy,
                                                  input logic [ADDR_W-1:0] xx);
    return yy * ADDR_W'(BOARD_W) + xx;
  endfunction

  // idx walks the 4x4 box row-major; mask bit 15-idx is the same as bit ~idx.
  always_comb begin
    mask    = shape_mask(block_q);
    cell_x  = {2'b00, x_q} + {5'b0, idx_q[1:0]};
    cell_y  = {1'b0, y_q} + {5'b0, idx_q[3:2]};
    cell_on = mask[~idx_q] && (cell_x < 7'(BOARD_W)) && (cell_y < 7'(BOARD_H));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      block_q  <= '0;
      colour_q <= '0;
      idx_q    <= '0;
      row_q    <= '0;
      dst_q    <= '0;
      col_q    <= '0;
      ph_q     <= 1'b0;
      zero_q   <= 1'b0;
      full_q   <= 1'b0;
      lines_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      block_q  <= block_d;
      colour_q <= colour_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      dst_q    <= dst_d;
      col_q    <= col_d;
      ph_q     <= ph_d;
      zero_q   <= zero_d;
      full_q   <= full_d;
      lines_q  <= lines_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    block_d  = block_q;
    colour_d = colour_q;
    idx_d    = idx_q;
    row_d    = row_q;
    dst_d    = dst_q;
    col_d    = col_q;
    ph_d     = ph_q;
    zero_d   = zero_q;
    full_d   = full_q;
    lines_d  = lines_q;
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    complete = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          x_d      = X_anchor;
          y_d      = Y_anchor;
          block_d  = block;
          colour_d = colour_in;
          lines_d  = '0;
          idx_d    = '0;
          state_d  = S_WRITE;
        end
      end

      S_WRITE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          if (cell_on) begin
            ram_addr = cell_addr(ADDR_W'(cell_y), ADDR_W'(cell_x));
            ram_data = colour_q;
            ram_wren = 1'b1;
          end
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'hF) begin
            state_d = S_SCAN;
            row_d   = ROW_W'(BOARD_H - 1);
            col_d   = '0;
            full_d  = 1'b1;
          end
        end
      end

      // Cycle col issues the read of column col and checks column col-1;
      // the extra cycle at col == BOARD_W checks the last column.
      S_SCAN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          if (col_q < COL_W'(BOARD_W)) begin
            ram_addr = cell_addr(ADDR_W'(row_q), ADDR_W'(col_q));
          end
          if ((col_q != '0) && (ram_Q == '0)) begin
            full_d = 1'b0;
          end
          col_d = col_q + COL_W'(1);
          if (col_q == COL_W'(BOARD_W)) begin
            col_d = '0;
            if (full_q && (ram_Q != '0)) begin
              lines_d = (lines_q == 3'd7) ? lines_q : lines_q + 3'd1;
              state_d = S_SHIFT;
              dst_d   = row_q;
              ph_d    = 1'b0;
              zero_d  = (row_q == '0);
            end else if (row_q == '0) begin
              state_d = S_DONE;
            end else begin
              row_d  = row_q - ROW_W'(1);
              full_d = 1'b1;
            end
          end
        end
      end

      S_SHIFT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (!zero_q) begin
          if (!ph_q) begin
            ram_addr = cell_addr(ADDR_W'(dst_q - ROW_W'(1)), ADDR_W'(col_q));
            ph_d     = 1'b1;
          end else begin
            ram_addr = cell_addr(ADDR_W'(dst_q), ADDR_W'(col_q));
            ram_data = ram_Q;
            ram_wren = 1'b1;
            ph_d     = 1'b0;
            if (col_q == COL_W'(BOARD_W - 1)) begin
              col_d = '0;
              if (dst_q == ROW_W'(1)) begin
                zero_d = 1'b1;
              end else begin
                dst_d = dst_q - ROW_W'(1);
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end else begin
          ram_addr = cell_addr('0, ADDR_W'(col_q));
          ram_wren = 1'b1;
          if (col_q == COL_W'(BOARD_W - 1)) begin
            col_d   = '0;
            zero_d  = 1'b0;
            full_d  = 1'b1;
            state_d = S_SCAN;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      S_DONE: begin
        complete = 1'b1;
        state_d  = enable ? S_HOLD : S_IDLE;
      end

      S_HOLD: begin
        if (!enable) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_piece_lock.sv
// Scoreboard bench for piece_lock: a behavioural board RAM, queued expectations
// for piece writes and completions, and board comparisons against a row-clear model.
module tb_piece_lock;
  localparam int W = 10;
  localparam int H = 20;
  localparam int AW = 8;
  localparam int N = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [4:0]    X_anchor;
  logic [5:0]    Y_anchor;
  logic [2:0]    block;
  logic [5:0]    colour_in;
  logic [5:0]    ram_Q;
  logic [AW-1:0] ram_addr;
  logic [5:0]    ram_data;
  logic          ram_wren;
  logic          busy;
  logic          complete;
  logic [2:0]    lines_cleared;

  int n_checks = 0;
  int n_fail = 0;
  int n_complete = 0;
  int bcnt = 0;

  logic [5:0] mem   [0:N-1];
  logic [5:0] model [0:N-1];

  logic       tb_we = 1'b0;
  logic       tb_clr = 1'b0;
  int         tb_wa = 0;
  logic [5:0] tb_wd = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [5:0]    data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [2:0] exp_lines[$];

  always #5 clk = ~clk;

  piece_lock #(.BOARD_W(W), .BOARD_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .X_anchor(X_anchor), .Y_anchor(Y_anchor), .block(block), .colour_in(colour_in),
    .ram_Q(ram_Q), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .complete(complete), .lines_cleared(lines_cleared)
  );

  // Board RAM with one-cycle read latency; the bench port preloads cells.
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end else if (ram_wren && (int'(ram_addr) < N)) begin
      mem[ram_addr] <= ram_data;
    end
    ram_Q <= (int'(ram_addr) < N) ? mem[ram_addr] : 6'h00;
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: piece writes fall in the first 16 busy cycles; completions pop lines.
  always @(negedge clk) begin
    if (busy) begin
      chk(int'(ram_addr) < N, "addr_in_range", int'(ram_addr), N - 1);
      if ((bcnt < 16) && ram_wren) begin
        if (exp_wr.size() == 0) begin
          chk(1'b0 == ram_wren, "unexpected_write", int'(ram_addr), -1);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk((ram_addr == e.addr) && (ram_data == e.data), "piece_write",
              int'({ram_addr, ram_data}), int'({e.addr, e.data}));
        end
      end
      bcnt++;
    end else begin
      chk(!ram_wren, "wren_while_idle", int'(ram_wren), 0);
      bcnt = 0;
    end
    if (complete) begin
      n_complete++;
      chk(exp_wr.size() == 0, "writes_outstanding", exp_wr.size(), 0);
      if (exp_lines.size() == 0) begin
        chk(!complete, "unexpected_complete", int'(lines_cleared), -1);
      end else begin
        logic [2:0] el;
        el = exp_lines.pop_front();
        chk(lines_cleared == el, "lines_cleared", int'(lines_cleared), int'(el));
      end
    end
  end

  function automatic logic [15:0] bmask(input int b);
    case (b)
      0: return 16'h0F00;
      1: return 16'h6600;
      2: return 16'h4E00;
      3: return 16'h6C00;
      4: return 16'hC600;
      5: return 16'h8E00;
      6: return 16'h2E00;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_commit(input int x, input int y, input int b, input logic [5:0] c);
    logic [15:0] m;
    m = bmask(b);
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (m[15 - (r * 4 + cc)] && (x + cc < W) && (y + r < H)) model[(y + r) * W + x + cc] = c;
  endtask

  task automatic model_clear();
    int y;
    y = H - 1;
    while (y >= 0) begin
      bit full;
      full = 1'b1;
      for (int x = 0; x < W; x++) if (model[y * W + x] == 6'h00) full = 1'b0;
      if (full) begin
        for (int d = y; d > 0; d--)
          for (int x = 0; x < W; x++) model[d * W + x] = model[(d - 1) * W + x];
        for (int x = 0; x < W; x++) model[x] = 6'h00;
      end else begin
        y--;
      end
    end
  endtask

  task automatic check_board(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < N; i++) if ((mem[i] !== model[i]) && (bad < 0)) bad = i;
    chk(bad < 0, name, bad, -1);
    if (bad >= 0) $display("  cell %0d: board %0h model %0h", bad, mem[bad], model[bad]);
  endtask

  task automatic clear_board();
    @(negedge clk);
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 6'h00;
  endtask

  task automatic poke(input int x, input int y, input logic [5:0] v);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = y * W + x;
    tb_wd = v;
    @(negedge clk);
    tb_we = 1'b0;
    model[y * W + x] = v;
  endtask

  task automatic push_wr(input int a, input logic [5:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic start(input int x, input int y, input int b, input logic [5:0] c);
    @(negedge clk);
    X_anchor  = 5'(x);
    Y_anchor  = 6'(y);
    block     = 3'(b);
    colour_in = c;
    enable    = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (complete) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no complete, expected complete within 3000 cycles", name);
    end
  endtask

  task automatic finish_op(input string name);
    wait_done(name);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(!busy, {name, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int c0;
    int low;
    reset     = 1'b1;
    enable    = 1'b0;
    X_anchor  = '0;
    Y_anchor  = '0;
    block     = 3'd7;
    colour_in = '0;
    repeat (3) @(negedge clk);
    chk(!busy, "rst_busy", int'(busy), 0);
    chk(!complete, "rst_complete", int'(complete), 0);
    chk(!ram_wren, "rst_wren", int'(ram_wren), 0);
    chk(ram_addr == '0, "rst_addr", int'(ram_addr), 0);
    chk(lines_cleared == '0, "rst_lines", int'(lines_cleared), 0);
    reset = 1'b0;

    // O piece at the bottom of an empty board
    clear_board();
    push_wr(185, 6'h2A); push_wr(186, 6'h2A); push_wr(195, 6'h2A); push_wr(196, 6'h2A);
    exp_lines.push_back(3'd0);
    model_commit(4, 18, 1, 6'h2A);
    model_clear();
    start(4, 18, 1, 6'h2A);
    finish_op("t1");
    check_board("t1_board");

    // I piece completes row 19
    clear_board();
    for (int x = 4; x < W; x++) poke(x, 19, 6'h11);
    poke(2, 18, 6'h05); poke(9, 18, 6'h07); poke(0, 0, 6'h3F); poke(6, 10, 6'h0C);
    push_wr(190, 6'h33); push_wr(191, 6'h33); push_wr(192, 6'h33); push_wr(193, 6'h33);
    exp_lines.push_back(3'd1);
    model_commit(0, 18, 0, 6'h33);
    model_clear();
    start(0, 18, 0, 6'h33);
    finish_op("t2");
    chk(mem[192] == 6'h05, "t2_drop_row18", int'(mem[192]), 5);
    chk(mem[0] == 6'h00, "t2_row0_empty", int'(mem[0]), 0);
    chk(mem[10] == 6'h3F, "t2_row0_to_row1", int'(mem[10]), 63);
    check_board("t2_board");

    // four full rows, no piece
    clear_board();
    for (int y = 16; y < H; y++)
      for (int x = 0; x < W; x++) if (x != 5) poke(x, y, 6'h1F);
    for (int y = 16; y < H; y++) poke(5, y, 6'h3E);
    poke(3, 15, 6'h09);
    exp_lines.push_back(3'd4);
    model_clear();
    start(0, 0, 7, 6'h21);
    finish_op("t3");
    chk(mem[193] == 6'h09, "t3_row15_to_19", int'(mem[193]), 9);
    check_board("t3_board");

    // T piece clipped at the right edge
    clear_board();
    push_wr(9, 6'h15); push_wr(18, 6'h15); push_wr(19, 6'h15);
    exp_lines.push_back(3'd0);
    model_commit(8, 0, 2, 6'h15);
    model_clear();
    start(8, 0, 2, 6'h15);
    finish_op("t4");
    check_board("t4_board");

    // enable held after completion
    clear_board();
    push_wr(102, 6'h01); push_wr(110, 6'h01); push_wr(111, 6'h01); push_wr(112, 6'h01);
    exp_lines.push_back(3'd0);
    model_commit(0, 10, 6, 6'h01);
    c0 = n_complete;
    start(0, 10, 6, 6'h01);
    wait_done("t5");
    low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) low++;
    end
    chk(low == 0, "hold_busy_low_cycles", low, 0);
    chk(n_complete - c0 == 1, "hold_complete_count", n_complete - c0, 1);
    enable = 1'b0;
    @(negedge clk);
    chk(!busy, "hold_release", int'(busy), 0);
    push_wr(53, 6'h02); push_wr(54, 6'h02); push_wr(64, 6'h02); push_wr(65, 6'h02);
    exp_lines.push_back(3'd0);
    model_commit(3, 5, 4, 6'h02);
    start(3, 5, 4, 6'h02);
    @(negedge clk);
    chk(busy, "restart_busy", int'(busy), 1);
    finish_op("t5b");
    check_board("t5_board");

    // asynchronous reset in the middle of SHIFT
    clear_board();
    for (int x = 0; x < W; x++) poke(x, 19, 6'h2D);
    start(0, 0, 7, 6'h2D);
    repeat (34) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk(!busy, "arst_busy", int'(busy), 0);
    chk(!ram_wren, "arst_wren", int'(ram_wren), 0);
    chk(ram_addr == '0, "arst_addr", int'(ram_addr), 0);
    chk(ram_data == '0, "arst_data", int'(ram_data), 0);
    chk(lines_cleared == '0, "arst_lines", int'(lines_cleared), 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk(mem[190] == 6'h00, "arst_partial_copy", int'(mem[190]), 0);
    chk(mem[199] == 6'h2D, "arst_untouched", int'(mem[199]), 45);
    for (int x = 0; x < 3; x++) model[190 + x] = 6'h00;
    push_wr(1, 6'h0A); push_wr(2, 6'h0A); push_wr(11, 6'h0A); push_wr(12, 6'h0A);
    exp_lines.push_back(3'd0);
    model_commit(0, 0, 1, 6'h0A);
    model_clear();
    start(0, 0, 1, 6'h0A);
    finish_op("t6");
    check_board("t6_board");

    chk(exp_wr.size() == 0, "leftover_writes", exp_wr.size(), 0);
    chk(exp_lines.size() == 0, "leftover_completes", exp_lines.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_lock.md
Name: piece_lock

Overview:
- Responder on the board-RAM write side, started by the game controller once a falling tetromino has landed.
- Commits the landed piece's four cells into ram_board, then scans the board bottom-up, removes every full row, and shifts the rows above it down.
- Uses the same enable/complete handshake as the collision and draw_tetromino modules.
- It is the writer of the board state those modules read.

Parameters:
- BOARD_W, 10, board width in cells.
- BOARD_H, 20, board height in cells.
- ADDR_W, 8, ram_board address width; cell address = y*BOARD_W + x.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  start/hold request from controller (module_select bit).
- X_anchor  input  5  column of the piece's 4x4 box top-left cell.
- Y_anchor  input  6  row of the piece's 4x4 box top-left cell; row 0 is the top.
- block  input  3  piece id 0..6 (I,O,T,S,Z,J,L); 7 = none.
- colour_in  input  6  colour written for the piece; 0 means empty and is never written by the piece.
- ram_Q  input  6  ram_board read data, valid 1 cycle after ram_addr.
- ram_addr  output  ADDR_W  ram_board address.
- ram_data  output  6  ram_board write data.
- ram_wren  output  1  ram_board write enable.
- busy  output  1  high in any state except IDLE.
- complete  output  1  one-cycle pulse when the commit and all clears are done.
- lines_cleared  output  3  number of rows removed by the last operation (0..4), held until the next start.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Asynchronous reset takes effect mid-operation and leaves partial board writes in place.
- Shape masks are 16 bits, row-major; bit 15 = (row0,col0) and bit 12 = (row0,col3):
  - I 0x0F00, O 0x6600, T 0x4E00, S 0x6C00, Z 0xC600, J 0x8E00, L 0x2E00, block 7 = 0x0000.
  - Mask bit (r,c) maps to board cell (X_anchor+c, Y_anchor+r).
- States:
  - IDLE: if enable=1, latch X_anchor, Y_anchor, block and colour_in; clear lines_cleared; go to WRITE.
  - WRITE: 16 cycles, one mask bit per cycle (bit 15 first). ram_wren=1 only for set bits whose cell has x<BOARD_W and y<BOARD_H; off-board cells are silently skipped. Then go to SCAN with row = BOARD_H-1.
  - SCAN:
    - Drive addresses x=0..BOARD_W-1 of the current row on consecutive cycles and check ram_Q one cycle later.
    - If any cell is 0 the row is not full: decrement row, or go to DONE after row 0.
    - If all cells are nonzero, increment lines_cleared (saturating at 7) and go to SHIFT.
  - SHIFT:
    - For dst = row down to 1 and each x: read (x,dst-1), then write that value to (x,dst). Each cell takes 2 cycles: address then write.
    - Then write 0 to every cell of row 0.
    - Return to SCAN on the same row, since the dropped row may now be full too.
  - DONE: complete=1 for exactly one cycle. If enable is still 1 go to HOLD, otherwise go to IDLE.
  - HOLD: wait for enable=0, then go to IDLE. This prevents a retrigger while the controller keeps enable high.
- Enable deasserted during WRITE, SCAN or SHIFT: abort to IDLE on the next cycle with ram_wren=0 and complete not pulsed. Board contents are then undefined by design, and the controller must not do this.
- ram_wren is never asserted outside WRITE and SHIFT.
- ram_data = colour_in (latched) in WRITE, the copied value in SHIFT, and 0 otherwise.
- Address arithmetic is done at ADDR_W bits; out-of-range cells never produce an address.
- busy rises the cycle after IDLE sees enable=1 and falls when the state returns to IDLE.

Test Plan:
- Empty board; enable with block=1 (O), X=4, Y=18, colour 0x2A -> exactly 4 writes, to addresses 185, 186, 195, 196 with data 0x2A. Then complete pulses once with lines_cleared=0, and the board is otherwise unchanged.
- Row 19 prefilled except x=0..3; block=0 (I), X=0, Y=18 -> row 19 cleared, lines_cleared=1. Row 18 contents move to row 19, and row 0 becomes all 0.
- Rows 16..19 prefilled except x=5; I piece vertical is not available, so place 4 single-column fills by hand and trigger with block=7 -> no WRITE writes, and after the fills lines_cleared=4. Cells marked at row 15 end up in row 19.
- block=2 (T), X=8, Y=0 -> cells with x=10 are skipped, and only (9,0) and (8,1), (9,1) are written. No address ≥200 ever appears.
- Keep enable=1 for 100 cycles after complete -> exactly one complete pulse and busy stays 1 in HOLD. After enable=0, busy goes to 0 and a new enable starts a new WRITE.
- Assert reset in the middle of SHIFT -> outputs are 0 immediately, with no clock edge needed. The next enable restarts from WRITE.
